// File: rtl/gb_vga_scaler.sv
// gb_vga_scaler: VGA timing plus integer-scaled, centred GB framebuffer.
// Define GB_SCALER_BORDER_EN for a 1-pixel coloured outline around the window.
module gb_vga_scaler #(
  parameter int H_PIXELS = 640,
  parameter int H_FP     = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BP     = 48,
  parameter int H_POL    = 0,
  parameter int V_PIXELS = 480,
  parameter int V_FP     = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BP     = 33,
  parameter int V_POL    = 1,
  parameter int SRC_W    = 160,
  parameter int SRC_H    = 144,
  parameter int SCALE    = 2,
  parameter int ADDR_W   = 15
) (
  input  logic              CLK_25MHz,
  input  logic              reset,
  output logic [ADDR_W-1:0] fb_raddr,
  input  logic [1:0]        fb_rdata,
  input  logic [1:0]        palette_sel,
  output logic [1:0]        vga_r,
  output logic [1:0]        vga_g,
  output logic [1:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic              frame_start
);

  localparam int H_TOTAL = H_PIXELS + H_FP + H_PULSE + H_BP;
  localparam int V_TOTAL = V_PIXELS + V_FP + V_PULSE + V_BP;
  localparam int WIN_W   = SRC_W * SCALE;
  localparam int WIN_H   = SRC_H * SCALE;
  localparam int X0      = (H_PIXELS - WIN_W) / 2;
  localparam int Y0      = (V_PIXELS - WIN_H) / 2;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  if (SCALE < 1 || SCALE > 3 ||
      WIN_W > H_PIXELS || WIN_H > V_PIXELS ||
      SRC_W * SRC_H > (1 << ADDR_W)) begin : g_cfg_err
    $error("gb_vga_scaler: window or address width out of range");
  end

  typedef logic [HW-1:0]     hc_t;
  typedef logic [VW-1:0]     vc_t;
  typedef logic [ADDR_W-1:0] ad_t;

  localparam hc_t H_LAST = hc_t'(H_TOTAL - 1);
  localparam hc_t H_ACT  = hc_t'(H_PIXELS - 1);
  localparam hc_t HS_B   = hc_t'(H_PIXELS + H_FP);
  localparam hc_t HS_E   = hc_t'(H_PIXELS + H_FP + H_PULSE - 1);
  localparam hc_t X_B    = hc_t'(X0);
  localparam hc_t X_E    = hc_t'(X0 + WIN_W - 1);
  localparam vc_t V_LAST = vc_t'(V_TOTAL - 1);
  localparam vc_t V_ACT  = vc_t'(V_PIXELS - 1);
  localparam vc_t VS_B   = vc_t'(V_PIXELS + V_FP);
  localparam vc_t VS_E   = vc_t'(V_PIXELS + V_FP + V_PULSE - 1);
  localparam vc_t Y_B    = vc_t'(Y0);
  localparam vc_t Y_E    = vc_t'(Y0 + WIN_H - 1);

  localparam logic       HPOL     = (H_POL != 0);
  localparam logic       VPOL     = (V_POL != 0);
  localparam logic [1:0] SC_M1    = 2'(SCALE - 1);
  localparam ad_t        ROW_STEP = ad_t'(SRC_W);

  logic       run;
  hc_t        h;
  vc_t        v;
  vc_t        v_nxt;
  logic       h_last;
  logic       x_in;
  logic       y_in;
  ad_t        col;
  ad_t        row_base;
  logic [1:0] sx;
  logic [1:0] sy;
  logic [1:0] pal_q;

  logic win1, de1, hs1, vs1, fs1;
  logic win2, de2, hs2, vs2, fs2;
  logic [5:0] pal_px;
  logic [5:0] rgb_n;

  assign h_last = (h == H_LAST);
  assign v_nxt  = (v == V_LAST) ? '0 : v + vc_t'(1);
  assign x_in   = (h >= X_B) && (h <= X_E);
  assign y_in   = (v >= Y_B) && (v <= Y_E);

  // run holds the counters at (0,0) for the first edge after reset.
  always_ff @(posedge CLK_25MHz) begin
    if (reset) begin
      run      <= 1'b0;
      h        <= '0;
      v        <= '0;
      col      <= '0;
      sx       <= '0;
      row_base <= '0;
      sy       <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (x_in) begin
          if (sx == SC_M1) begin
            sx  <= '0;
            col <= col + ad_t'(1);
          end else begin
            sx <= sx + 2'd1;
          end
        end
        if (h_last) begin
          h   <= '0;
          v   <= v_nxt;
          sx  <= '0;
          col <= '0;
          if (y_in) begin
            if (sy == SC_M1) begin
              sy       <= '0;
              row_base <= row_base + ROW_STEP;
            end else begin
              sy <= sy + 2'd1;
            end
          end
          if (v_nxt == Y_B) begin
            sy       <= '0;
            row_base <= '0;
          end
        end else begin
          h <= h + hc_t'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_25MHz) begin
    if (reset) begin
      pal_q <= '0;
    end else if (run && h == '0 && v == '0) begin
      pal_q <= palette_sel;
    end
  end

  always_ff @(posedge CLK_25MHz) begin
    if (reset) begin
      fb_raddr <= '0;
      win1     <= 1'b0;
      de1      <= 1'b0;
      hs1      <= ~HPOL;
      vs1      <= ~VPOL;
      fs1      <= 1'b0;
    end else if (run) begin
      if (x_in && y_in) begin
        fb_raddr <= row_base + col;
      end
      win1 <= x_in && y_in;
      de1  <= (h <= H_ACT) && (v <= V_ACT);
      hs1  <= (h >= HS_B && h <= HS_E) ? HPOL : ~HPOL;
      vs1  <= (v >= VS_B && v <= VS_E) ? VPOL : ~VPOL;
      fs1  <= (h == '0) && (v == '0);
    end
  end

  always_ff @(posedge CLK_25MHz) begin
    if (reset) begin
      win2 <= 1'b0;
      de2  <= 1'b0;
      hs2  <= ~HPOL;
      vs2  <= ~VPOL;
      fs2  <= 1'b0;
    end else begin
      win2 <= win1;
      de2  <= de1;
      hs2  <= hs1;
      vs2  <= vs1;
      fs2  <= fs1;
    end
  end

`ifdef GB_SCALER_BORDER_EN
  localparam hc_t X_L = hc_t'(X0 - 1);
  localparam hc_t X_R = hc_t'(X0 + WIN_W);
  localparam vc_t Y_T = vc_t'(Y0 - 1);
  localparam vc_t Y_M = vc_t'(Y0 + WIN_H);

  // 1 = side column, 2 = top row, 3 = bottom row; corners never match.
  logic [1:0] bord0, bord1, bord2;

  always_comb begin
    bord0 = 2'd0;
    unique case (1'b1)
      ((h == X_L) || (h == X_R)) && y_in: bord0 = 2'd1;
      (v == Y_T) && x_in:                 bord0 = 2'd2;
      (v == Y_M) && x_in:                 bord0 = 2'd3;
      default:                            bord0 = 2'd0;
    endcase
  end

  always_ff @(posedge CLK_25MHz) begin
    if (reset) begin
      bord1 <= '0;
      bord2 <= '0;
    end else begin
      if (run) begin
        bord1 <= bord0;
      end
      bord2 <= bord1;
    end
  end
`endif

  always_comb begin
    pal_px = '0;
    unique case (pal_q)
      2'd1: begin
        unique case (fb_rdata)
          2'd0:    pal_px = 6'b10_11_01;
          2'd1:    pal_px = 6'b01_10_01;
          2'd2:    pal_px = 6'b00_01_00;
          default: pal_px = 6'b00_00_00;
        endcase
      end
      2'd2:    pal_px = {3{fb_rdata}};
      default: pal_px = {3{~fb_rdata}};
    endcase
  end

  always_comb begin
    rgb_n = '0;
    unique case (1'b1)
      !de2: rgb_n = '0;
      win2: rgb_n = pal_px;
`ifdef GB_SCALER_BORDER_EN
      default: begin
        unique case (bord2)
          2'd1:    rgb_n = 6'b11_00_00;
          2'd2:    rgb_n = 6'b00_11_00;
          2'd3:    rgb_n = 6'b11_11_00;
          default: rgb_n = 6'b00_00_00;
        endcase
      end
`else
      default: rgb_n = '0;
`endif
    endcase
  end

  always_ff @(posedge CLK_25MHz) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= ~HPOL;
      vga_vs      <= ~VPOL;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb_n;
      vga_hs      <= hs2;
      vga_vs      <= vs2;
      vga_de      <= de2;
      frame_start <= fs2;
    end
  end

endmodule

// File: tb/tb_gb_vga_scaler.sv
// tb_gb_vga_scaler: two small-geometry scaler instances (x2, x3) against
// an arithmetic frame model with random framebuffer and palette changes.
module tb_gb_vga_scaler;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
  } out_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] palette_sel;

  logic [5:0] raddr [2];
  logic [1:0] rdata [2];
  logic [1:0] vr [2];
  logic [1:0] vg [2];
  logic [1:0] vb [2];
  logic       hs [2];
  logic       vs [2];
  logic       de [2];
  logic       fs [2];

  logic [1:0] mem [2][64];

  int hp [2]   = '{24, 30};
  int hfp [2]  = '{2, 2};
  int hpw [2]  = '{3, 3};
  int hbp [2]  = '{3, 3};
  int hpol [2] = '{0, 1};
  int vp [2]   = '{16, 22};
  int vfp [2]  = '{1, 1};
  int vpw [2]  = '{2, 2};
  int vbp [2]  = '{2, 2};
  int vpol [2] = '{1, 0};
  int sw [2]   = '{8, 8};
  int sh [2]   = '{6, 6};
  int sc [2]   = '{2, 3};

  int fpal [2][16];
  int la [2];
  int e;
  int total;
  int bad;
  int phase;
  int de_cnt;
  int fs_q [$];

  always #20 clk = ~clk;

  always @(posedge clk) begin
    rdata[0] <= mem[0][raddr[0]];
    rdata[1] <= mem[1][raddr[1]];
  end

  gb_vga_scaler #(
    .H_PIXELS(24), .H_FP(2), .H_PULSE(3), .H_BP(3), .H_POL(0),
    .V_PIXELS(16), .V_FP(1), .V_PULSE(2), .V_BP(2), .V_POL(1),
    .SRC_W(8), .SRC_H(6), .SCALE(2), .ADDR_W(6)
  ) u_s2 (
    .CLK_25MHz(clk), .reset(reset),
    .fb_raddr(raddr[0]), .fb_rdata(rdata[0]),
    .palette_sel(palette_sel),
    .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]),
    .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_de(de[0]),
    .frame_start(fs[0])
  );

  gb_vga_scaler #(
    .H_PIXELS(30), .H_FP(2), .H_PULSE(3), .H_BP(3), .H_POL(1),
    .V_PIXELS(22), .V_FP(1), .V_PULSE(2), .V_BP(2), .V_POL(0),
    .SRC_W(8), .SRC_H(6), .SCALE(3), .ADDR_W(6)
  ) u_s3 (
    .CLK_25MHz(clk), .reset(reset),
    .fb_raddr(raddr[1]), .fb_rdata(rdata[1]),
    .palette_sel(palette_sel),
    .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]),
    .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_de(de[1]),
    .frame_start(fs[1])
  );

  function automatic int htot(int k);
    return hp[k] + hfp[k] + hpw[k] + hbp[k];
  endfunction

  function automatic int frm(int k);
    return htot(k) * (vp[k] + vfp[k] + vpw[k] + vbp[k]);
  endfunction

  function automatic int x0(int k);
    return (hp[k] - sw[k] * sc[k]) / 2;
  endfunction

  function automatic int y0(int k);
    return (vp[k] - sh[k] * sc[k]) / 2;
  endfunction

  function automatic bit inx(int k, int h);
    return h >= x0(k) && h < x0(k) + sw[k] * sc[k];
  endfunction

  function automatic bit iny(int k, int v);
    return v >= y0(k) && v < y0(k) + sh[k] * sc[k];
  endfunction

  function automatic int addr_of(int k, int h, int v);
    return ((v - y0(k)) / sc[k]) * sw[k] + (h - x0(k)) / sc[k];
  endfunction

  function automatic logic [5:0] pal_rgb(int sel, int px);
    logic [5:0] c;
    c = 6'b00_00_00;
    case (sel)
      1: case (px)
           0: c = {2'd2, 2'd3, 2'd1};
           1: c = {2'd1, 2'd2, 2'd1};
           2: c = {2'd0, 2'd1, 2'd0};
           default: c = {2'd0, 2'd0, 2'd0};
         endcase
      2: case (px)
           0: c = {2'd0, 2'd0, 2'd0};
           1: c = {2'd1, 2'd1, 2'd1};
           2: c = {2'd2, 2'd2, 2'd2};
           default: c = {2'd3, 2'd3, 2'd3};
         endcase
      default: case (px)
           0: c = {2'd3, 2'd3, 2'd3};
           1: c = {2'd2, 2'd2, 2'd2};
           2: c = {2'd1, 2'd1, 2'd1};
           default: c = {2'd0, 2'd0, 2'd0};
         endcase
    endcase
    return c;
  endfunction

  // n = index of the counter value in the run since reset release
  function automatic out_t model(int k, int n);
    out_t o;
    int p, h, v, fr, hs0, vs0, wr, wb;
    o = '0;
    o.hs = (hpol[k] == 0);
    o.vs = (vpol[k] == 0);
    if (n < 0) return o;
    fr = n / frm(k);
    p = n % frm(k);
    h = p % htot(k);
    v = p / htot(k);
    hs0 = hp[k] + hfp[k];
    vs0 = vp[k] + vfp[k];
    if (h >= hs0 && h < hs0 + hpw[k]) o.hs = (hpol[k] != 0);
    if (v >= vs0 && v < vs0 + vpw[k]) o.vs = (vpol[k] != 0);
    o.de = (h < hp[k]) && (v < vp[k]);
    o.fs = (p == 0);
    wr = x0(k) + sw[k] * sc[k];
    wb = y0(k) + sh[k] * sc[k];
    if (o.de) begin
      if (inx(k, h) && iny(k, v)) begin
        {o.r, o.g, o.b} = pal_rgb(fpal[k][fr],
                                  int'(mem[k][addr_of(k, h, v)]));
      end
`ifdef GB_SCALER_BORDER_EN
      else if ((h == x0(k) - 1 || h == wr) && iny(k, v)) begin
        {o.r, o.g, o.b} = {2'd3, 2'd0, 2'd0};
      end else if (v == y0(k) - 1 && inx(k, h)) begin
        {o.r, o.g, o.b} = {2'd0, 2'd3, 2'd0};
      end else if (v == wb && inx(k, h)) begin
        {o.r, o.g, o.b} = {2'd3, 2'd3, 2'd0};
      end
`endif
    end
    return o;
  endfunction

  task automatic chk(int k, string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL u%0d.%s obs=%0d exp=%0d e=%0d",
             k, tag, obs, exp, e);
    end
  endtask

  task automatic check_inst(int k);
    out_t x;
    int m, p, h, v;
    x = model(k, e - 4);
    chk(k, "r", 32'(vr[k]), 32'(x.r));
    chk(k, "g", 32'(vg[k]), 32'(x.g));
    chk(k, "b", 32'(vb[k]), 32'(x.b));
    chk(k, "hs", 32'(hs[k]), 32'(x.hs));
    chk(k, "vs", 32'(vs[k]), 32'(x.vs));
    chk(k, "de", 32'(de[k]), 32'(x.de));
    chk(k, "fs", 32'(fs[k]), 32'(x.fs));
    m = e - 2;
    if (e == 0) begin
      la[k] = 0;
    end else if (m >= 0) begin
      p = m % frm(k);
      h = p % htot(k);
      v = p / htot(k);
      if (inx(k, h) && iny(k, v)) la[k] = addr_of(k, h, v);
    end
    chk(k, "addr", 32'(raddr[k]), 32'(la[k]));
  endtask

  task automatic step();
    int ci;
    @(posedge clk);
    e = reset ? 0 : e + 1;
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    if (phase == 0) begin
      if (fs[0]) fs_q.push_back(e);
      if (e >= 4 && e < 4 + frm(0) && de[0]) de_cnt++;
    end
    if (!reset && e >= 1) begin
      if ($urandom_range(0, 149) == 0)
        palette_sel = 2'($urandom_range(0, 3));
      ci = e - 1;
      for (int k = 0; k < 2; k++) begin
        if (ci % frm(k) == 0 && ci / frm(k) < 16)
          fpal[k][ci / frm(k)] = int'(palette_sel);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    e = 0;
    phase = 0;
    de_cnt = 0;
    la[0] = 0;
    la[1] = 0;
    reset = 1'b1;
    palette_sel = 2'd0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) mem[k][i] = 2'($urandom_range(0, 3));
      for (int f = 0; f < 16; f++) fpal[k][f] = 0;
    end
    mem[0][0] = 2'd0;

    repeat (5) step();
    reset = 1'b0;
    repeat (2800) step();

    chk(0, "fs_first", 32'(fs_q.size() > 0 ? fs_q[0] : -1), 32'(4));
    chk(0, "fs_period",
        32'(fs_q.size() > 1 ? fs_q[1] - fs_q[0] : -1), 32'(672));
    chk(0, "de_frame", 32'(de_cnt), 32'(24 * 16));

    phase = 1;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    palette_sel = 2'd2;
    repeat (1500) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
